// File: rtl/pal_sram_scanner.sv
// PAL raster scanner: sweeps an HTOTAL x VTOTAL raster, fetches one RGB332 byte per
// active pixel from asynchronous SRAM and drives 9-bit RGB plus composite sync.
module pal_sram_scanner #(
    parameter int          HTOTAL       = 448,
    parameter int          VTOTAL       = 312,
    parameter int          HSTART       = 48,
    parameter int          VSTART       = 64,
    parameter int          HBLANK_START = 320,
    parameter int          HBLANK_END   = 416,
    parameter int          HSYNC_START  = 344,
    parameter int          HSYNC_LEN    = 32,
    parameter int          VBLANK_START = 272,
    parameter int          VBLANK_END   = 280,
    parameter int          VSYNC_START  = 272,
    parameter int          VSYNC_LEN    = 4,
    parameter logic [18:0] FB_BASE      = 19'h00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  border,
    output logic [18:0] sram_addr,
    input  logic [7:0]  sram_data,
    output logic        sram_we_n,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [2:0]  b,
    output logic        csync,
    output logic        frame_start
);

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT0 = HW'(HSTART);
    localparam logic [HW-1:0] H_ACT1 = HW'(HSTART + 256);
    localparam logic [HW-1:0] H_BLK0 = HW'(HBLANK_START);
    localparam logic [HW-1:0] H_BLK1 = HW'(HBLANK_END);
    localparam logic [HW-1:0] H_SYN0 = HW'(HSYNC_START);
    localparam logic [HW-1:0] H_SYN1 = HW'(HSYNC_START + HSYNC_LEN);

    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT0 = VW'(VSTART);
    localparam logic [VW-1:0] V_ACT1 = VW'(VSTART + 192);
    localparam logic [VW-1:0] V_BLK0 = VW'(VBLANK_START);
    localparam logic [VW-1:0] V_BLK1 = VW'(VBLANK_END);
    localparam logic [VW-1:0] V_SYN0 = VW'(VSYNC_START);
    localparam logic [VW-1:0] V_SYN1 = VW'(VSYNC_START + VSYNC_LEN);

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;

    logic       active, blank, hs, vs, first;
    logic [7:0] hoff, voff;

    logic       active_d, blank_d, hs_d, vs_d, first_d;
    logic [8:0] border_d;

    assign sram_we_n = 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign active = (hc >= H_ACT0) && (hc < H_ACT1) && (vc >= V_ACT0) && (vc < V_ACT1);
    assign blank  = ((hc >= H_BLK0) && (hc < H_BLK1)) || ((vc >= V_BLK0) && (vc < V_BLK1));
    assign hs     = (hc >= H_SYN0) && (hc < H_SYN1);
    assign vs     = (vc >= V_SYN0) && (vc < V_SYN1);
    assign first  = (hc == '0) && (vc == '0);

    // Offsets into the 256x192 window; only meaningful (and only used) when active.
    assign hoff = 8'(hc - H_ACT0);
    assign voff = 8'(vc - V_ACT0);

    // Stage 1: address fetch and region flags; border is delayed with them so a
    // border change lines up with the raster position it was sampled at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= FB_BASE;
            active_d  <= 1'b0;
            blank_d   <= 1'b0;
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            first_d   <= 1'b0;
            border_d  <= '0;
        end else begin
            if (active)
                sram_addr <= FB_BASE + {3'b000, voff, hoff};
            active_d <= active;
            blank_d  <= blank;
            hs_d     <= hs;
            vs_d     <= vs;
            first_d  <= first;
            border_d <= border;
        end
    end

    // Stage 2: sram_data here answers the address registered one edge earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            csync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (blank_d) begin
                r <= '0;
                g <= '0;
                b <= '0;
            end else if (active_d) begin
                r <= sram_data[7:5];
                g <= sram_data[4:2];
                b <= {sram_data[1:0], sram_data[1]};
            end else begin
                r <= border_d[8:6];
                g <= border_d[5:3];
                b <= border_d[2:0];
            end
            // XOR inverts hsync during vsync lines, giving equalising-style pulses.
            csync       <= ~(hs_d ^ vs_d);
            frame_start <= first_d;
        end
    end

endmodule

// File: doc/pal_sram_scanner.md
Name: pal_sram_scanner

Overview:
- Read-only PAL video scanner for the board test core: sweeps a 448x312 raster at the 7 MHz pixel clock.
- Fetches one byte per active pixel from the external SRAM framebuffer and decodes it as RGB332.
- Drives the 9-bit r/g/b bus and composite csync on the top-level video pins, with border colour outside the 256x192 window.
- Sits directly downstream of the SRAM, in place of the video side of the machine instance.

Parameters:
- HTOTAL, 448, pixel clocks per line (hc counts 0..HTOTAL-1).
- VTOTAL, 312, lines per frame (vc counts 0..VTOTAL-1).
- HSTART, 48, first hc of the active window (256 pixels wide, fixed).
- VSTART, 64, first vc of the active window (192 lines tall, fixed).
- HBLANK_START, 320 and HBLANK_END, 416, horizontal blank spans hc in [320,416).
- HSYNC_START, 344 and HSYNC_LEN, 32, hsync spans hc in [344,376).
- VBLANK_START, 272 and VBLANK_END, 280, vertical blank spans vc in [272,280).
- VSYNC_START, 272 and VSYNC_LEN, 4, vsync spans vc in [272,276).
- FB_BASE, 19'h00000, SRAM byte address of pixel (0,0).

Ports:
- clk  in  1  pixel clock (clk7 domain).
- rst_n  in  1  asynchronous active-low reset.
- border  in  9  border colour {R[2:0],G[2:0],B[2:0]}, sampled every cycle.
- sram_addr  out  19  SRAM read address.
- sram_data  in  8  SRAM read data, asynchronous SRAM.
- sram_we_n  out  1  tied high, read-only block.
- r  out  3  red.
- g  out  3  green.
- b  out  3  blue.
- csync  out  1  composite sync, active low.
- frame_start  out  1  one-cycle pulse, aligned with output of raster position (0,0).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hc=0, vc=0, sram_addr=FB_BASE.
  - r=g=b=0, csync=1, frame_start=0.
  - All pipeline flags are cleared.
  - Reset mid-frame aborts the frame; after release, scanning restarts at (0,0).
- Counters:
  - hc increments every clk.
  - At hc=HTOTAL-1, hc wraps to 0 and vc increments.
  - At vc=VTOTAL-1 with hc=HTOTAL-1, vc wraps to 0.
  - No other event alters the counters.
- Region decode on (hc,vc):
  - active = HSTART<=hc<HSTART+256 && VSTART<=vc<VSTART+192.
  - blank = hc in hblank || vc in vblank.
  - hs = hc in hsync window; vs = vc in vsync window.
  - Everything else is border.
- Stage 1 (registered on each clk edge):
  - sram_addr <= FB_BASE + ((vc-VSTART)<<8) + (hc-HSTART), truncated to 19 bits, when active.
  - When not active, sram_addr holds its last value.
  - The flags active, blank, hs, vs and first=(hc==0&&vc==0) are registered alongside.
- Stage 2 (registered on the next edge):
  - If blank_d: rgb=0.
  - Else if active_d: r=sram_data[7:5], g=sram_data[4:2], b={sram_data[1:0],sram_data[1]}.
  - Else: rgb=border.
  - csync <= ~(hs_d ^ vs_d), so sync is inverted during vsync lines (equalising-style).
  - frame_start <= first_d.
- Latency:
  - All outputs lag the counter position by exactly 2 clk edges; rgb, csync and frame_start stay mutually aligned.
  - SRAM access time must be under one clk period (~140 ns).
- sram_we_n=1 at all times, including during reset.
- Border changes take effect 2 cycles after sampling. There is no frame-level latching.
- Priority: blank overrides active and border. Parameter sets where windows overlap are illegal and are not checked.

Test Plan:
- Reset release: hold rst_n=0 for 5 cycles, then release. During reset r/g/b=0, csync=1, sram_we_n=1. frame_start pulses exactly 2 cycles after release, then every 139776 cycles (448x312).
- Address sweep: at (hc,vc)=(48,64) expect sram_addr=0x00000 one edge later. At (303,255) expect 0x0BFFF (191*256+255). With FB_BASE=0x7F000 the last pixel wraps to 0x0AFFF.
- Pixel decode: the SRAM model returns 0xE3 for address 0. Two edges after (48,64), expect r=7, g=0, b=3'b111. With data 0x1C expect r=0, g=7, b=0.
- Border/blank: border=9'h1C7, sample at (20,100) → rgb=1C7. At (330,100) → rgb=0. At (100,275) → rgb=0.
- Sync shape: on line vc=100, csync is low for exactly 32 cycles starting 2 cycles after hc=344. On vc=273, csync is high for those 32 cycles and low for the other 416.
- Mid-frame reset: assert rst_n at (200,150) for 1 cycle. Outputs go to reset values immediately (asynchronously). After release the counters restart at 0 and frame_start fires 2 cycles later.
